// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: command/response handshake bundle for alu_ctrl.
//   cmd_*  : operation request (valid/ready), operands a/b, 2-bit opcode
//   rsp_*  : result return (valid/ready), 8-bit data, opcode echo, error flag
// master = requester/consumer side, slave = the controller.
interface alu_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_op;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_op, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_op, rsp_err
  );
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl: sequential front end for the 4-bit ALU.
//   Accepts one command at a time, drives registered operands + start to the
//   ALU, waits SETTLE_CYCLES, captures total and returns it on the response
//   channel. op_count counts completed response handshakes (wraps).
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   io (alu_ctrl_if.slave): cmd_* request, rsp_* response
//   alu_start/a/b/sel     : registered drive to the ALU
//   alu_total             : ALU result
//   busy                  : controller not in IDLE
//   op_count              : completed-operation counter
// Optional feature: define ALU_CTRL_DIVZERO_CHK_EN to short-circuit divide by
// zero (result 0xFF, rsp_err=1, ALU untouched). Undefined: rsp_err is always 0.
module alu_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_ctrl_if.slave        io,
  output logic             alu_start,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_sel,
  input  logic [7:0]       alu_total,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, RESP} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             alu_start_q, alu_start_d;
  logic [3:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]       alu_sel_q, alu_sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic [1:0]       rsp_op_q, rsp_op_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             divz;

  // Without the check, divide by zero is just another ALU command, so the
  // short-circuit branch below is never taken and rsp_err stays 0.
`ifdef ALU_CTRL_DIVZERO_CHK_EN
  assign divz = (io.cmd_op == 2'b11) && (io.cmd_b == 4'd0);
`else
  assign divz = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    alu_start_d = alu_start_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_op_d    = rsp_op_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (io.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (divz) begin
            // ALU is never started; answer immediately.
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'hFF;
            rsp_op_d    = 2'b11;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end else begin
            alu_a_d     = io.cmd_a;
            alu_b_d     = io.cmd_b;
            alu_sel_d   = io.cmd_op;
            alu_start_d = 1'b1;
            state_d     = DRIVE;
          end
        end
      end
      DRIVE: begin
        cnt_d   = 4'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d  = alu_total;
          rsp_op_d    = alu_sel_q;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          alu_start_d = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_valid_q && io.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 1'b1;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      alu_start_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      alu_start_q <= alu_start_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_op_q    <= rsp_op_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      op_count_q  <= op_count_d;
    end
  end

  assign io.cmd_ready = cmd_ready_q;
  assign io.rsp_valid = rsp_valid_q;
  assign io.rsp_data  = rsp_data_q;
  assign io.rsp_op    = rsp_op_q;
  assign io.rsp_err   = rsp_err_q;
  assign alu_start    = alu_start_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_sel      = alu_sel_q;
  assign busy         = busy_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: scoreboard bench. Two controllers share clock/reset:
//   u0: SETTLE_CYCLES=1, CNT_W=8   u1: SETTLE_CYCLES=4, CNT_W=2
// Each has a behavioural ALU that outputs junk (0xAA) until start has been
// high long enough, so an early capture is visible.
module tb_alu_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic sel1;
  always #5 clk = ~clk;

  logic       cmd_valid, rsp_ready;
  logic [3:0] cmd_a, cmd_b;
  logic [1:0] cmd_op;

  alu_ctrl_if if0 ();
  alu_ctrl_if if1 ();

  logic       st0, st1;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] s0, s1;
  logic [7:0] tot0, tot1;
  logic       busy0, busy1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  assign if0.cmd_valid = cmd_valid & ~sel1;
  assign if0.cmd_a     = cmd_a;
  assign if0.cmd_b     = cmd_b;
  assign if0.cmd_op    = cmd_op;
  assign if0.rsp_ready = rsp_ready & ~sel1;
  assign if1.cmd_valid = cmd_valid & sel1;
  assign if1.cmd_a     = cmd_a;
  assign if1.cmd_b     = cmd_b;
  assign if1.cmd_op    = cmd_op;
  assign if1.rsp_ready = rsp_ready & sel1;

  alu_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .io(if0.slave), .alu_start(st0), .alu_a(a0),
    .alu_b(b0), .alu_sel(s0), .alu_total(tot0), .busy(busy0), .op_count(cnt0));
  alu_ctrl #(.SETTLE_CYCLES(4), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .io(if1.slave), .alu_start(st1), .alu_a(a1),
    .alu_b(b1), .alu_sel(s1), .alu_total(tot1), .busy(busy1), .op_count(cnt1));

  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] op);
    case (op)
      2'b00:   return {4'h0, a} + {4'h0, b};
      2'b01:   return {4'h0, a} - {4'h0, b};
      2'b10:   return {4'h0, a} * {4'h0, b};
      default: return (b == 4'd0) ? 8'h0F : {4'h0, a / b};
    endcase
  endfunction

  // ALU models: result only valid once start has been high >= SETTLE cycles
  int hi0 = 0, hi1 = 0;
  always @(posedge clk) begin
    hi0 <= st0 ? hi0 + 1 : 0;
    hi1 <= st1 ? hi1 + 1 : 0;
  end
  assign tot0 = !st0 ? 8'h00 : (hi0 >= 1) ? alu_f(a0, b0, s0) : 8'hAA;
  assign tot1 = !st1 ? 8'h00 : (hi1 >= 4) ? alu_f(a1, b1, s1) : 8'hAA;

  // muxed view of the selected DUT
  logic       m_rdy, m_rv, m_err, m_st, m_busy;
  logic [7:0] m_data, m_cnt;
  logic [1:0] m_op;
  logic [3:0] m_a;
  always_comb begin
    m_rdy  = sel1 ? if1.cmd_ready : if0.cmd_ready;
    m_rv   = sel1 ? if1.rsp_valid : if0.rsp_valid;
    m_data = sel1 ? if1.rsp_data  : if0.rsp_data;
    m_op   = sel1 ? if1.rsp_op    : if0.rsp_op;
    m_err  = sel1 ? if1.rsp_err   : if0.rsp_err;
    m_st   = sel1 ? st1 : st0;
    m_a    = sel1 ? a1 : a0;
    m_busy = sel1 ? busy1 : busy0;
    m_cnt  = sel1 ? {6'd0, cnt1} : cnt0;
  end

  typedef struct {
    logic [7:0] data;
    logic [1:0] op;
    logic       err;
    int         lat;
    int         starts;
    logic [3:0] a;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0, n_err = 0;
  int exp_cnt0 = 0, exp_cnt1 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op, input int bp);
    exp_t e, f;
    int g, lat, starts, st;
    logic [7:0] mask;
    st = sel1 ? 4 : 1;
    mask = sel1 ? 8'h03 : 8'hFF;
    e.a = a;
`ifdef ALU_CTRL_DIVZERO_CHK_EN
    if (op == 2'b11 && b == 4'd0) begin
      e.data = 8'hFF; e.op = 2'b11; e.err = 1'b1; e.lat = 1; e.starts = 0;
    end else
`endif
    begin
      e.data = alu_f(a, b, op); e.op = op; e.err = 1'b0;
      e.lat = 2 + st; e.starts = st + 1;
    end
    g = 0;
    while (!m_rdy && g < 20) begin tick(); g++; end
    chk("cmd_ready_idle", {31'd0, m_rdy}, 1);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    sb.push_back(e);
    tick();
    // junk command while busy must be ignored
    cmd_a = ~a; cmd_b = ~b; cmd_op = ~op;
    lat = 1; starts = 0;
    while (!m_rv && lat < 40) begin
      starts += m_st;
      tick();
      lat++;
    end
    starts += m_st;
    for (int i = 0; i < bp; i++) begin
      chk("hold_data", {24'd0, m_data}, {24'd0, e.data});
      chk("cmd_ready_busy", {31'd0, m_rdy}, 0);
      chk("count_before_hs", {24'd0, m_cnt}, (sel1 ? exp_cnt1 : exp_cnt0) & mask);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    f = sb.pop_front();
    chk("rsp_valid", {31'd0, m_rv}, 1);
    chk("latency", lat, f.lat);
    chk("start_cycles", starts, f.starts);
    chk("rsp_data", {24'd0, m_data}, {24'd0, f.data});
    chk("rsp_op", {30'd0, m_op}, {30'd0, f.op});
    chk("rsp_err", {31'd0, m_err}, {31'd0, f.err});
    tick();
    rsp_ready = 1'b0;
    if (sel1) exp_cnt1++; else exp_cnt0++;
    chk("op_count", {24'd0, m_cnt}, (sel1 ? exp_cnt1 : exp_cnt0) & mask);
    chk("rsp_valid_clr", {31'd0, m_rv}, 0);
    chk("cmd_ready_post", {31'd0, m_rdy}, 1);
    chk("busy_post", {31'd0, m_busy}, 0);
    if (f.starts > 0) chk("alu_a_hold", {28'd0, m_a}, {28'd0, f.a});
  endtask

  initial begin
    rst_n = 1'b0; sel1 = 1'b0;
    cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'd0, if0.cmd_ready & if1.cmd_ready}, 1);
    chk("rst_start", {30'd0, st0, st1}, 0);
    chk("rst_alu_ops", {20'd0, a0, b0, s0, s1}, 0);
    chk("rst_rsp", {22'd0, if0.rsp_valid, if0.rsp_err, if0.rsp_data}, 0);
    chk("rst_busy_cnt", {21'd0, busy0, busy1, cnt0}, 0);
    rst_n = 1'b1;
    tick();

    do_op(4'd3, 4'd5, 2'b00, 0);   // add -> 0x08
    do_op(4'd2, 4'd5, 2'b01, 0);   // sub wrap -> 0xFD
    do_op(4'd7, 4'd9, 2'b10, 5);   // mul with backpressure -> 0x3F
    do_op(4'd9, 4'd0, 2'b11, 2);   // divide by zero
    do_op(4'd15, 4'd15, 2'b10, 1); // mul max -> 0xE1
    sel1 = 1'b1;
    do_op(4'd13, 4'd4, 2'b11, 0);  // div, settle 4 -> 0x03

    // reset during SETTLE: no response, count cleared
    sel1 = 1'b0;
    cmd_valid = 1'b1; cmd_a = 4'd1; cmd_b = 4'd2; cmd_op = 2'b00;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rv", {31'd0, if0.rsp_valid}, 0);
    chk("mid_rst_cnt", {24'd0, cnt0}, 0);
    chk("mid_rst_state", {29'd0, busy0, st0, if0.cmd_ready}, 1);
    tick();
    rst_n = 1'b1;
    exp_cnt0 = 0; exp_cnt1 = 0;
    begin
      int seen = 0;
      for (int i = 0; i < 5; i++) begin
        seen += if0.rsp_valid;
        tick();
      end
      chk("mid_rst_no_rsp", seen, 0);
    end

    // counter wrap on the 2-bit instance
    sel1 = 1'b1;
    do_op(4'd1, 4'd1, 2'b00, 0);
    do_op(4'd4, 4'd6, 2'b01, 0);
    do_op(4'd3, 4'd3, 2'b10, 0);
    do_op(4'd8, 4'd3, 2'b11, 0);
    do_op(4'd6, 4'd5, 2'b00, 0);
    chk("wrap_count", {30'd0, cnt1}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
